// File: rtl/cmp_event_monitor_pkg.sv
// Shared types for the comparator event monitor: result kinds, FSM state codes
// and the one-hot flag decoder.
package cmp_mon_pkg;

    typedef enum logic [1:0] {
        KIND_NONE    = 2'b00,
        KIND_LESS    = 2'b01,
        KIND_GREATER = 2'b10,
        KIND_EQUAL   = 2'b11
    } kind_t;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_TRACK = 2'd1;
    localparam state_t ST_ALARM = 2'd2;

    typedef struct packed {
        logic  illegal;
        kind_t kind;
    } decode_t;

    // Anything other than exactly one flag high is illegal and decodes to NONE.
    function automatic decode_t onehot3_to_kind(input logic less, input logic equal,
                                                input logic greater);
        decode_t d;
        d.illegal = 1'b0;
        d.kind    = KIND_NONE;
        case ({less, equal, greater})
            3'b100:  d.kind = KIND_LESS;
            3'b010:  d.kind = KIND_EQUAL;
            3'b001:  d.kind = KIND_GREATER;
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cmp_event_monitor_if.sv
// Sample/status bundle between the comparator source and the event monitor.
interface cmp_event_monitor_if #(
    parameter int CNT_W    = 8,
    parameter int STREAK_N = 4
);
    localparam int SW = $clog2(STREAK_N + 1);

    logic             clr;
    logic             in_valid;
    logic             less;
    logic             equal;
    logic             greater;
    logic [CNT_W-1:0] cnt_less;
    logic [CNT_W-1:0] cnt_equal;
    logic [CNT_W-1:0] cnt_greater;
    logic [SW-1:0]    streak;
    logic             alarm;
    logic [1:0]       alarm_kind;
    logic             err;

    modport master (
        output clr, in_valid, less, equal, greater,
        input  cnt_less, cnt_equal, cnt_greater, streak, alarm, alarm_kind, err
    );

    modport slave (
        input  clr, in_valid, less, equal, greater,
        output cnt_less, cnt_equal, cnt_greater, streak, alarm, alarm_kind, err
    );
endinterface

// File: rtl/cmp_event_monitor_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/cmp_event_monitor.sv
// Monitors comparator less/equal/greater flags: per-kind counts, run length of
// the current kind, sticky persistent-mismatch alarm and illegal-pattern error.
module cmp_event_monitor
    import cmp_mon_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int STREAK_N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    cmp_event_monitor_if.slave   mon
);

    localparam int SW = $clog2(STREAK_N + 1);

    decode_t       dec;
    logic          legal;
    logic          illegal;
    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_nxt;
    kind_t         last_kind;
    state_t        state;
    logic          alarm_q;
    kind_t         alarm_kind_q;
    logic          err_q;

    // clr drops any sample presented alongside it.
    assign dec     = onehot3_to_kind(mon.less, mon.equal, mon.greater);
    assign legal   = mon.in_valid && !dec.illegal && !mon.clr;
    assign illegal = mon.in_valid &&  dec.illegal && !mon.clr;

    sat_counter #(.W(CNT_W)) u_cnt_less (
        .clk (clk), .rst (rst), .clr (mon.clr),
        .inc (legal && (dec.kind == KIND_LESS)),
        .q   (mon.cnt_less)
    );

    sat_counter #(.W(CNT_W)) u_cnt_equal (
        .clk (clk), .rst (rst), .clr (mon.clr),
        .inc (legal && (dec.kind == KIND_EQUAL)),
        .q   (mon.cnt_equal)
    );

    sat_counter #(.W(CNT_W)) u_cnt_greater (
        .clk (clk), .rst (rst), .clr (mon.clr),
        .inc (legal && (dec.kind == KIND_GREATER)),
        .q   (mon.cnt_greater)
    );

    always_comb begin
        streak_nxt = SW'(1);
        if (dec.kind == last_kind) begin
            streak_nxt = (streak_q == SW'(STREAK_N)) ? streak_q : streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || mon.clr) begin
            streak_q     <= '0;
            last_kind    <= KIND_NONE;
            state        <= ST_IDLE;
            alarm_q      <= 1'b0;
            alarm_kind_q <= KIND_NONE;
            err_q        <= 1'b0;
        end else if (illegal) begin
            err_q     <= 1'b1;
            streak_q  <= '0;
            last_kind <= KIND_NONE;
        end else if (legal) begin
            streak_q  <= streak_nxt;
            last_kind <= dec.kind;
            case (state)
                ST_IDLE: state <= ST_TRACK;
                ST_TRACK: begin
                    // Only a mismatch run can raise the alarm; equal runs just saturate.
                    if ((dec.kind != KIND_EQUAL) && (streak_nxt == SW'(STREAK_N))) begin
                        state        <= ST_ALARM;
                        alarm_q      <= 1'b1;
                        alarm_kind_q <= dec.kind;
                    end
                end
                default: state <= ST_ALARM;
            endcase
        end
    end

    assign mon.streak     = streak_q;
    assign mon.alarm      = alarm_q;
    assign mon.alarm_kind = alarm_kind_q;
    assign mon.err        = err_q;

endmodule

// File: tb/tb_cmp_event_monitor.sv
// Drives one flag stream into an 8-bit and a 3-bit-counter monitor and checks
// both every cycle against a run-length model of the flag history.
module tb_cmp_event_monitor;

    localparam int STREAK_N = 4;

    logic clk;
    logic rst;
    bit   cmp_en;
    int   total;
    int   passed;

    cmp_event_monitor_if #(.CNT_W(8), .STREAK_N(STREAK_N)) bus8 ();
    cmp_event_monitor_if #(.CNT_W(3), .STREAK_N(STREAK_N)) bus3 ();

    cmp_event_monitor #(.CNT_W(8), .STREAK_N(STREAK_N)) dut8 (
        .clk (clk), .rst (rst), .mon (bus8.slave)
    );

    cmp_event_monitor #(.CNT_W(3), .STREAK_N(STREAK_N)) dut3 (
        .clk (clk), .rst (rst), .mon (bus3.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: unbounded counts and run length, saturated only when compared.
    int raw [4];
    int run;
    int last;
    bit m_alarm;
    int m_kind;
    bit m_err;

    always @(posedge clk) begin
        int nflags;
        int k;
        if (rst || bus8.clr) begin
            for (int i = 0; i < 4; i++) raw[i] = 0;
            run = 0; last = 0; m_alarm = 0; m_kind = 0; m_err = 0;
        end else if (bus8.in_valid) begin
            nflags = int'(bus8.less) + int'(bus8.equal) + int'(bus8.greater);
            if (nflags != 1) begin
                m_err = 1; run = 0; last = 0;
            end else begin
                k = bus8.less ? 1 : (bus8.greater ? 2 : 3);
                raw[k]++;
                if (k == last) run++;
                else begin run = 1; last = k; end
                if (!m_alarm && k != 3 && run >= STREAK_N) begin
                    m_alarm = 1; m_kind = k;
                end
            end
        end
    end

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("w8.cnt_less",    int'(bus8.cnt_less),    sat(raw[1], 8));
            check("w8.cnt_greater", int'(bus8.cnt_greater), sat(raw[2], 8));
            check("w8.cnt_equal",   int'(bus8.cnt_equal),   sat(raw[3], 8));
            check("w8.streak",      int'(bus8.streak),      (run > STREAK_N) ? STREAK_N : run);
            check("w8.alarm",       int'(bus8.alarm),       int'(m_alarm));
            check("w8.alarm_kind",  int'(bus8.alarm_kind),  m_kind);
            check("w8.err",         int'(bus8.err),         int'(m_err));
            check("w3.cnt_less",    int'(bus3.cnt_less),    sat(raw[1], 3));
            check("w3.cnt_greater", int'(bus3.cnt_greater), sat(raw[2], 3));
            check("w3.cnt_equal",   int'(bus3.cnt_equal),   sat(raw[3], 3));
            check("w3.streak",      int'(bus3.streak),      (run > STREAK_N) ? STREAK_N : run);
            check("w3.alarm",       int'(bus3.alarm),       int'(m_alarm));
            check("w3.alarm_kind",  int'(bus3.alarm_kind),  m_kind);
            check("w3.err",         int'(bus3.err),         int'(m_err));
        end
    end

    task automatic applyStimulus(input logic v, input logic l, input logic e,
                                 input logic g, input logic c);
        @(negedge clk);
        bus8.in_valid = v; bus8.less = l; bus8.equal = e; bus8.greater = g; bus8.clr = c;
        bus3.in_valid = v; bus3.less = l; bus3.equal = e; bus3.greater = g; bus3.clr = c;
    endtask

    // Gaps present garbage flags with in_valid low; they must be ignored.
    task automatic idle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input int cl, input int ce, input int cg,
                               input int st, input int al, input int ak, input int er);
        check({tag, ".cnt_less"},    int'(bus8.cnt_less),    cl);
        check({tag, ".cnt_equal"},   int'(bus8.cnt_equal),   ce);
        check({tag, ".cnt_greater"}, int'(bus8.cnt_greater), cg);
        check({tag, ".streak"},      int'(bus8.streak),      st);
        check({tag, ".alarm"},       int'(bus8.alarm),       al);
        check({tag, ".alarm_kind"},  int'(bus8.alarm_kind),  ak);
        check({tag, ".err"},         int'(bus8.err),         er);
    endtask

    initial begin
        total = 0; passed = 0; cmp_en = 0;
        rst = 1'b1;
        bus8.in_valid = 0; bus8.less = 0; bus8.equal = 0; bus8.greater = 0; bus8.clr = 0;
        bus3.in_valid = 0; bus3.less = 0; bus3.equal = 0; bus3.greater = 0; bus3.clr = 0;
        @(posedge clk);
        cmp_en = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset", 0, 0, 0, 0, 0, 0, 0);

        // One of each legal kind: 10<12, 15>11, 10==10.
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(1, 0, 1, 0, 0);
        idle();
        checkOutput("one_each", 1, 1, 1, 1, 0, 0, 0);

        // Four greaters separated by invalid gaps raise the alarm on the 4th.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 1, 0);
            idle();
        end
        checkOutput("gt_alarm", 1, 1, 5, 4, 1, 2, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        idle();
        checkOutput("kind_frozen", 3, 1, 5, 2, 1, 2, 0);

        // Equal runs saturate the streak but never alarm.
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 1, 0, 0);
        idle();
        checkOutput("eq_run", 0, 6, 0, 4, 0, 0, 0);

        // Two flags high, then no flags high.
        applyStimulus(1, 1, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0);
        idle();
        checkOutput("illegal", 0, 6, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 0);
        idle();
        checkOutput("after_illegal", 1, 6, 0, 1, 0, 0, 1);

        // Nine lesses: saturates the 3-bit counter, alarms with kind less.
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) applyStimulus(1, 1, 0, 0, 0);
        idle();
        checkOutput("lt_nine", 9, 0, 0, 4, 1, 1, 0);
        check("w3.cnt_less_sat", int'(bus3.cnt_less), 7);

        // clr beats a simultaneous legal sample.
        applyStimulus(1, 1, 0, 0, 1);
        idle();
        checkOutput("clr_wins", 0, 0, 0, 0, 0, 0, 0);
        check("w3.clr_wins", int'(bus3.cnt_less), 0);
        applyStimulus(1, 1, 0, 0, 0);
        idle();
        checkOutput("after_clr", 1, 0, 0, 1, 0, 0, 0);

        // Reset in the middle of a greater run discards the history.
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 1, 0);
        idle();
        rst = 1'b1;
        applyStimulus(1, 0, 0, 1, 0);
        rst = 1'b0;
        applyStimulus(1, 0, 0, 1, 0);
        idle();
        checkOutput("rst_mid", 0, 0, 2, 2, 0, 0, 0);

        idle();
        cmp_en = 0;
        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
